// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch reset/vector defaults, NOP encoding, IF/ID record.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam logic [31:0] IRQ_VECTOR_DEFAULT = 32'h0000_0100;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } if_id_t;

    // Control-flow event selected by the fetch stage in a given cycle.
    typedef enum logic [1:0] {
        EV_NONE,
        EV_REDIRECT,
        EV_RTI,
        EV_IRQ
    } fetch_event_e;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer: holds the instruction-memory return that arrives on
// the first stalled cycle so it can be handed to IF/ID when the stall ends.
module fetch_skid
    import cpu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_capture,
    input  logic        i_release,
    input  logic        i_flush,
    input  logic [31:0] i_data,
    output logic [31:0] o_data,
    output logic        o_valid
);

    logic [31:0] r_data;
    logic        r_valid;

    // Flush beats release beats capture; only the first capture of a stall is kept.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_data  <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_flush || i_release) begin
            r_valid <= 1'b0;
        end else if (i_capture && !r_valid) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register: PC ownership, 1-cycle imem,
// stall absorption via skid buffer, EX redirects, rti and interrupt entry.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] IRQ_VECTOR = IRQ_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hazard,
    input  logic        stall_mem,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        rti,
    input  logic        irq,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic        imem_en,
    output logic [31:0] instruction,
    output logic [31:0] next_pc,
    output logic [31:0] pc_id,
    output logic        flush_dec,
    output logic [31:0] epc,
    output logic        in_isr
);

    logic [31:0]  r_pc_f;
    logic [31:0]  r_fq_pc;
    logic         r_fq_v;
    if_id_t       r_if_id;
    logic [31:0]  r_next_pc;
    logic [31:0]  r_epc;
    logic         r_in_isr;

    logic         w_hold;
    logic         w_flush;
    fetch_event_e w_event;
    logic [31:0]  w_target;
    logic [31:0]  w_skid_data;
    logic         w_skid_v;
    if_id_t       w_fetched;

    assign w_hold = hazard | stall_mem;

    // Event selection: only with the memory side free; hazard does not block
    // redirect/rti since the hazarding instruction is squashed anyway.
    always_comb begin
        w_event  = EV_NONE;
        w_target = r_pc_f;
        if (!stall_mem) begin
            if (redirect) begin
                w_event  = EV_REDIRECT;
                w_target = redirect_target;
            end else if (rti) begin
                w_event  = EV_RTI;
                w_target = r_epc;
            end else if (irq && !r_in_isr && r_if_id.valid && !hazard) begin
                w_event  = EV_IRQ;
                w_target = IRQ_VECTOR;
            end
        end
    end

    assign w_flush = (w_event != EV_NONE);

    fetch_skid u_skid (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_capture (w_hold & r_fq_v),
        .i_release (~w_hold),
        .i_flush   (w_flush),
        .i_data    (imem_rdata),
        .o_data    (w_skid_data),
        .o_valid   (w_skid_v)
    );

    // Instruction entering IF/ID: a replayed skid entry takes precedence over imem.
    always_comb begin
        w_fetched.pc    = r_fq_pc;
        w_fetched.valid = r_fq_v;
        if (w_skid_v) begin
            w_fetched.instr = w_skid_data;
        end else if (r_fq_v) begin
            w_fetched.instr = imem_rdata;
        end else begin
            w_fetched.instr = NOP_INSTR;
        end
    end

    // PC, in-flight request and IF/ID register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc_f    <= RESET_PC;
            r_fq_pc   <= '0;
            r_fq_v    <= 1'b0;
            r_if_id   <= '{instr: NOP_INSTR, pc: '0, valid: 1'b0};
            r_next_pc <= 32'd4;
        end else if (w_flush) begin
            r_pc_f        <= w_target;
            r_fq_v        <= 1'b0;
            r_if_id.instr <= NOP_INSTR;
            r_if_id.valid <= 1'b0;
        end else if (!w_hold) begin
            r_pc_f    <= r_pc_f + 32'd4;
            r_fq_pc   <= r_pc_f;
            r_fq_v    <= 1'b1;
            r_if_id   <= w_fetched;
            r_next_pc <= r_fq_pc + 32'd4;
        end
    end

    // Interrupt bookkeeping: entry saves the squashed decode PC, rti leaves the handler.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_epc    <= '0;
            r_in_isr <= 1'b0;
        end else begin
            case (w_event)
                EV_RTI: r_in_isr <= 1'b0;
                EV_IRQ: begin
                    r_epc    <= r_if_id.pc;
                    r_in_isr <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign imem_addr   = r_pc_f;
    assign imem_en     = rst_n & ~w_hold;
    assign instruction = r_if_id.instr;
    assign pc_id       = r_if_id.pc;
    assign next_pc     = r_next_pc;
    assign flush_dec   = w_flush;
    assign epc         = r_epc;
    assign in_isr      = r_in_isr;

endmodule
